// File: rtl/pipe_stall_ctrl.sv
// Purpose : central stall/flush controller for the 5-stage pipeline (IF/ID/EX/MEM/WB).
// Latency : stall/busy/ex_mc_done are combinational; flush/flush_pc are registered (1 cycle after flush_req).
// Backpr. : ID/EX/MEM hold requests are ORed into a per-stage hold vector; a flush overrides every hold.
//
// Ports:
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   id_stall_req              ID operand hazard -> hold PC, IF/ID, ID/EX
//   mem_stall_req             MEM bus wait -> hold PC..MEM/WB; also freezes a multi-cycle op
//   ex_mc_start/ex_mc_cycles  start of an EX multi-cycle op and its length N (0 behaves as 1)
//   flush_req/flush_target    flush request and redirect PC
//   stall[5:0]                hold bits: [0]=PC [1]=IF/ID [2]=ID/EX [3]=EX/MEM [4]=MEM/WB [5]=WB (never set)
//   flush/flush_pc            clear all pipeline registers this cycle, redirect PC
//   ex_mc_done                one-cycle pulse when the multi-cycle result is valid
//   busy                      controller is not in its idle RUN state
// Optional build macro STALL_PERF_CNT_EN adds perf_stall_cycles / perf_flush_count.

module pipe_stall_ctrl #(
   parameter int MC_CNT_W = 6,
   parameter int ADDR_W   = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                id_stall_req,
   input  logic                mem_stall_req,
   input  logic                ex_mc_start,
   input  logic [MC_CNT_W-1:0] ex_mc_cycles,
   input  logic                flush_req,
   input  logic [ADDR_W-1:0]   flush_target,
   output logic [5:0]          stall,
   output logic                flush,
   output logic [ADDR_W-1:0]   flush_pc,
   output logic                ex_mc_done,
   output logic                busy
`ifdef STALL_PERF_CNT_EN
   ,
   output logic [31:0]         perf_stall_cycles,
   output logic [31:0]         perf_flush_count
`endif
);

   typedef enum logic [1:0] {
      S_RUN     = 2'd0,
      S_MC_BUSY = 2'd1,
      S_FLUSH   = 2'd2
   } state_t;

   localparam logic [5:0] HOLD_ID  = 6'b000111;
   localparam logic [5:0] HOLD_EX  = 6'b001111;
   localparam logic [5:0] HOLD_MEM = 6'b011111;

   state_t              state_q, state_d;
   logic [MC_CNT_W-1:0] cnt_q, cnt_d;
   logic                flush_d;
   logic [ADDR_W-1:0]   flush_pc_d;
   logic                ex_hold;
   logic                done;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_RUN;
         cnt_q    <= '0;
         flush    <= 1'b0;
         flush_pc <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         flush    <= flush_d;
         flush_pc <= flush_pc_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      flush_d    = 1'b0;
      flush_pc_d = flush_pc;
      ex_hold    = 1'b0;
      done       = 1'b0;

      case (state_q)
         S_RUN: begin
            // EX hold follows the start request even when a flush drops the start.
            ex_hold = ex_mc_start;
            if (flush_req) begin
               state_d    = S_FLUSH;
               flush_d    = 1'b1;
               flush_pc_d = flush_target;
            end else if (ex_mc_start) begin
               state_d = S_MC_BUSY;
               cnt_d   = (ex_mc_cycles == '0) ? MC_CNT_W'(1) : ex_mc_cycles;
            end
         end

         S_MC_BUSY: begin
            ex_hold = 1'b1;
            done    = (cnt_q == MC_CNT_W'(1)) && !mem_stall_req;
            if (flush_req) begin
               // Abort: the op is discarded, so no completion pulse follows.
               state_d    = S_FLUSH;
               cnt_d      = '0;
               flush_d    = 1'b1;
               flush_pc_d = flush_target;
            end else if (!mem_stall_req) begin
               // MEM back-pressure freezes the countdown so the result lines up with MEM.
               cnt_d = cnt_q - MC_CNT_W'(1);
               if (done) begin
                  state_d = S_RUN;
               end
            end
         end

         S_FLUSH: begin
            state_d = S_RUN;
         end

         default: begin
            state_d = S_RUN;
            cnt_d   = '0;
         end
      endcase
   end

   // Reset and flush both force the pipeline to free-run so the clear propagates.
   always_comb begin
      stall = 6'b000000;
      if (!rst && state_q != S_FLUSH) begin
         if (id_stall_req)  stall = stall | HOLD_ID;
         if (ex_hold)       stall = stall | HOLD_EX;
         if (mem_stall_req) stall = stall | HOLD_MEM;
      end
   end

   assign ex_mc_done = done && !rst;
   assign busy       = (state_q != S_RUN);

`ifdef STALL_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_stall_cycles <= '0;
         perf_flush_count  <= '0;
      end else begin
         if (stall[0]) perf_stall_cycles <= perf_stall_cycles + 32'd1;
         if (flush)    perf_flush_count  <= perf_flush_count + 32'd1;
      end
   end
`endif

endmodule
